// File: rtl/pack_upsizer_pkg.sv
// Shared sizing helpers for the width up-converter.
package pack_upsizer_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_RATIO = 4;
  // Lane-index width for the default ratio; instances derive their own via idx_width().
  localparam int unsigned DEF_IDX_W = $clog2(DEF_RATIO);

  function automatic int unsigned count_width(input int unsigned ratio);
    return $clog2(ratio + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/pack_upsizer.sv
// Packs ratio_p narrow words into one wide word; last_i flushes a partial word early.
module pack_upsizer
  import pack_upsizer_pkg::*;
#(
  parameter int unsigned width_p = DEF_WIDTH,
  parameter int unsigned ratio_p = DEF_RATIO
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                valid_i,
  input  logic [width_p-1:0]                  data_i,
  input  logic                                last_i,
  output logic                                ready_o,
  output logic                                valid_o,
  output logic [width_p*ratio_p-1:0]          data_o,
  output logic [count_width(ratio_p)-1:0]     count_o,
  output logic                                last_o,
  input  logic                                ready_i
);

  localparam int unsigned IDX_W = idx_width(ratio_p);
  localparam int unsigned CNT_W = count_width(ratio_p);
  localparam int unsigned DW    = width_p * ratio_p;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ratio_p - 1);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DW-1:0]    data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

  logic in_xfer;
  logic out_xfer;
  logic complete;

  assign ready_o  = ~reset_i & (~valid_q | ready_i);
  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_q & ready_i;
  assign complete = in_xfer & ((idx_q == LAST_IDX) | last_i);

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;
  assign last_o  = last_q;

  always_comb begin
    idx_d   = idx_q;
    data_d  = data_q;
    count_d = count_q;
    valid_d = valid_q;
    last_d  = last_q;

    // Lane 0 of a new word clears the remaining lanes so a flushed partial word reads zero above its fill.
    if (in_xfer) begin
      for (int unsigned k = 0; k < ratio_p; k++) begin
        if (IDX_W'(k) == idx_q) begin
          data_d[k*width_p +: width_p] = data_i;
        end else if (idx_q == '0) begin
          data_d[k*width_p +: width_p] = '0;
        end
      end
    end

    if (complete) begin
      valid_d = 1'b1;
      count_d = CNT_W'(idx_q) + CNT_W'(1);
      last_d  = last_i;
      idx_d   = '0;
    end else begin
      if (in_xfer) begin
        idx_d = idx_q + IDX_W'(1);
      end
      if (out_xfer) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idx_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      data_q  <= data_d;
      count_q <= count_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_pack_upsizer.sv
// Self-checking bench for pack_upsizer: lane-queue reference model plus directed literal checks.
module tb_pack_upsizer;
  import pack_upsizer_pkg::*;

  localparam int W  = 8;
  localparam int R  = 4;
  localparam int DW = W * R;
  localparam int CW = count_width(R);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_i = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic          last_i = 1'b0;
  logic          ready_i = 1'b0;
  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic [CW-1:0] count_o;
  logic          last_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pack_upsizer #(.width_p(W), .ratio_p(R)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .valid_i (valid_i),
    .data_i  (data_i),
    .last_i  (last_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .count_o (count_o),
    .last_o  (last_o),
    .ready_i (ready_i)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: collected lanes as a queue, pending output word as plain values.
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  int            m_count = 0;
  logic          m_last = 1'b0;
  logic [W-1:0]  lanes[$];

  always @(negedge clk) begin : cmp
    logic          exp_ready;
    logic          acc;
    logic          take;
    logic [DW-1:0] w;
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_count = 0;
      m_last  = 1'b0;
      lanes.delete();
      chk("rst_ready", ready_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_data",  data_o,  0);
      chk("rst_count", count_o, 0);
      chk("rst_last",  last_o,  0);
    end else begin
      exp_ready = !m_valid || ready_i;
      chk("ready", ready_o, exp_ready);
      chk("valid", valid_o, m_valid);
      if (m_valid) begin
        chk("data",  data_o,  m_data);
        chk("count", count_o, m_count);
        chk("last",  last_o,  m_last);
      end
      acc  = valid_i && exp_ready;
      take = m_valid && ready_i;
      if (take) m_valid = 1'b0;
      if (acc) begin
        lanes.push_back(data_i);
        if (lanes.size() == R || last_i) begin
          w = '0;
          foreach (lanes[k]) w = w | (DW'(lanes[k]) << (k * W));
          m_data  = w;
          m_count = lanes.size();
          m_last  = last_i;
          m_valid = 1'b1;
          lanes.delete();
        end
      end
    end
  end

  task automatic step(input logic v, input logic [W-1:0] d, input logic l);
    valid_i = v;
    data_i  = d;
    last_i  = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stalls;
    logic [DW-1:0] held;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready_o", ready_o, 0);
    chk("reset_valid_o", valid_o, 0);
    chk("reset_count_o", count_o, 0);
    chk("reset_data_o",  data_o,  0);
    rst = 1'b0;
    #1;
    chk("ready_after_release", ready_o, 1);
    ready_i = 1'b1;

    // Full-rate pack
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    chk("full_not_yet_valid", valid_o, 0);
    step(1, 8'h44, 0);
    chk("full_valid", valid_o, 1);
    chk("full_data",  data_o,  32'h44332211);
    chk("full_count", count_o, 4);
    chk("full_last",  last_o,  0);

    stalls = 0;
    for (int n = 0; n < 12; n++) begin
      if (!ready_o) stalls++;
      step(1, 8'(n + 1), 0);
    end
    chk("b2b_no_stall", stalls, 0);
    chk("b2b_word3", data_o, 32'h0C0B0A09);

    // Partial flush
    step(1, 8'hAA, 0);
    step(1, 8'hBB, 1);
    chk("flush_data",  data_o,  32'h0000BBAA);
    chk("flush_count", count_o, 2);
    chk("flush_last",  last_o,  1);
    step(1, 8'h55, 0);
    chk("flush_taken", valid_o, 0);
    step(1, 8'h66, 1);
    chk("flush2_data", data_o, 32'h00006655);

    // Backpressure
    step(0, 8'h00, 0);
    ready_i = 1'b0;
    step(1, 8'hA1, 0);
    step(1, 8'hA2, 0);
    step(1, 8'hA3, 0);
    step(1, 8'hA4, 0);
    chk("bp_data", data_o, 32'hA4A3A2A1);
    held = data_o;
    for (int n = 0; n < 5; n++) begin
      chk("bp_ready_low", ready_o, 0);
      chk("bp_held", data_o, held);
      chk("bp_count", count_o, 4);
      step(1, 8'hE1, 0);
    end
    ready_i = 1'b1;
    #1;
    chk("bp_ready_comb", ready_o, 1);
    step(1, 8'hE1, 0);
    chk("bp_taken", valid_o, 0);
    step(1, 8'hE2, 0);
    step(1, 8'hE3, 0);
    step(1, 8'hE4, 0);
    chk("bp_next_word", data_o, 32'hE4E3E2E1);

    // Single-word frame while the previous word drains
    step(1, 8'hCC, 1);
    chk("single_valid", valid_o, 1);
    chk("single_data",  data_o,  32'h000000CC);
    chk("single_count", count_o, 1);
    chk("single_last",  last_o,  1);

    // Asynchronous reset with a held word
    ready_i = 1'b0;
    step(0, 8'h00, 0);
    chk("held_before_reset", valid_o, 1);
    rst = 1'b1;
    #1;
    chk("async_valid", valid_o, 0);
    chk("async_count", count_o, 0);
    chk("async_data",  data_o,  0);
    chk("async_ready", ready_o, 0);
    step(0, 8'h00, 0);
    rst = 1'b0;
    ready_i = 1'b1;

    // Reset mid-word
    step(1, 8'h31, 0);
    step(1, 8'h32, 0);
    step(1, 8'h33, 0);
    valid_i = 1'b0;
    rst = 1'b1;
    step(0, 8'h00, 0);
    rst = 1'b0;
    step(1, 8'h41, 0);
    step(1, 8'h42, 0);
    step(1, 8'h43, 0);
    chk("midrst_no_emit", valid_o, 0);
    step(1, 8'h44, 0);
    chk("midrst_valid", valid_o, 1);
    chk("midrst_data",  data_o,  32'h44434241);
    chk("midrst_count", count_o, 4);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      ready_i = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 399) == 0);
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0);
    end
    rst = 1'b0;
    ready_i = 1'b1;
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
